data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 16 +
 rtl/mycpu.vh | 13 +
 rtl/sram_resp_fifo.sv | 61 ++++++
 rtl/data_sram_resp.sv | 82 ++++++++
 tb/tb_data_sram_resp.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/data_sram_resp_pkg.sv
// Types and defaults shared by the data SRAM responder and its response queue.
`include "mycpu.vh"

package data_sram_resp_pkg;
  localparam int DEF_ADDR_W    = `DSRAM_ADDR_W;
  localparam int DEF_LATENCY   = `DSRAM_LATENCY;
  localparam int DEF_MAX_OUTST = `DSRAM_MAX_OUTST;
  localparam int DATA_W        = `BUS_DATA_W;
  localparam int CD_W          = 2;

  typedef struct packed {
    logic              is_read;
    logic [DATA_W-1:0] rdata;
    logic [CD_W-1:0]   cd;
  } resp_ent_t;
endpackage

// File: rtl/mycpu.vh
// Shared bus widths and default geometry of the data SRAM responder.
`ifndef MYCPU_VH
`define MYCPU_VH

`define BUS_ADDR_W      32
`define BUS_DATA_W      32
`define BUS_STRB_W      4

`define DSRAM_ADDR_W    10
`define DSRAM_LATENCY   1
`define DSRAM_MAX_OUTST 2

`endif

// File: rtl/sram_resp_fifo.sv
// In-order response queue; every entry counts down to zero and the head pops when ready.
// Head is visible combinationally; push into a full queue is dropped (unreachable from the top).
module sram_resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  resp_ent_t     push_ent,
  input  logic          pop,
  output resp_ent_t     head,
  output logic          head_vld,
  output logic [CW-1:0] count
);

  resp_ent_t       ents [DEPTH];
  resp_ent_t       nxt  [DEPTH];
  logic [CW-1:0]   cnt_n;
  logic            do_pop;
  logic            do_push;

  assign head     = ents[0];
  assign head_vld = (count != '0);
  assign do_pop   = pop && head_vld;

  always_comb begin
    cnt_n   = count;
    do_push = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = ents[i];
      if (nxt[i].cd != '0) nxt[i].cd = nxt[i].cd - CD_W'(1);
    end
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) nxt[i] = nxt[i+1];
      nxt[DEPTH-1] = '0;
      cnt_n = count - CW'(1);
    end
    // New entries land behind the survivors and start their countdown next cycle.
    if (push && (int'(cnt_n) < DEPTH)) begin
      do_push = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(cnt_n)) nxt[i] = push_ent;
      end
    end
    if (do_push) cnt_n = cnt_n + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      count <= cnt_n;
      for (int i = 0; i < DEPTH; i++) ents[i] <= nxt[i];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM slave: accept when outstanding < MAX_OUTST, answer in order after LATENCY cycles.
// data_ok is never back-pressured; addr_ok is the only stall and drops while the queue is full.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [CW-1:0]     outstanding;
  resp_ent_t         push_ent;
  resp_ent_t         head;
  logic              head_vld;
  logic              pop;
  logic [31:0]       last_rdata;
  logic              unused_addr;

  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign data_sram_addr_ok = (outstanding < CW'(MAX_OUTST));
  assign accept            = data_sram_req && data_sram_addr_ok;

  // Reads sample the array before this edge's write, so same-cycle ordering never arises.
  always_comb begin
    push_ent.is_read = !data_sram_wr;
    push_ent.rdata   = data_sram_wr ? 32'h0 : mem[idx];
    push_ent.cd      = CD_W'(LATENCY - 1);
  end

  always_ff @(posedge clk) begin
    if (resetn && accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .head_vld (head_vld),
    .count    (outstanding)
  );

  assign pop               = head_vld && (head.cd == '0);
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && head.is_read) ? head.rdata : last_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_rdata <= 32'h0;
    end else if (pop && head.is_read) begin
      last_rdata <= head.rdata;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench: LATENCY=1 instance driven from a vector table, LATENCY=3 instance for stall/order/reset cases.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_a, req_b, wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok_a, dok_a, aok_b, dok_b;
  logic [31:0] rd_a, rd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .LATENCY(1), .MAX_OUTST(2)) u_a (
    .clk(clk), .resetn(resetn), .data_sram_req(req_a), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok_a), .data_sram_data_ok(dok_a), .data_sram_rdata(rd_a)
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(3), .MAX_OUTST(2)) u_b (
    .clk(clk), .resetn(resetn), .data_sram_req(req_b), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok_b), .data_sram_data_ok(dok_b), .data_sram_rdata(rd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_dok_b(input string name);
    int k = 0;
    while (!dok_b && k < 12) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'b0, dok_b}, 32'd1);
  endtask

  task automatic b_write(input logic [31:0] a, input logic [31:0] d);
    req_b = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = a; wdata = d;
    @(negedge clk);
    req_b = 1'b0; wr = 1'b0;
    wait_dok_b("preload_dok");
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];
  logic exp_ok  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic exp_dok [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int nacc, nrsp, seen;

    // exp is rdata in the response cycle; writes must leave the previous read value.
    vt[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000};
    vt[1]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_AAEF};
    vt[4]  = '{1'b0, 4'h0, 32'h0000_0103, 32'h0,         32'hDEAD_AAEF};
    vt[5]  = '{1'b1, 4'hF, 32'h0000_0200, 32'h1234_5678, 32'hDEAD_AAEF};
    vt[6]  = '{1'b1, 4'h0, 32'h0000_0200, 32'hFFFF_FFFF, 32'hDEAD_AAEF};
    vt[7]  = '{1'b0, 4'h0, 32'h0000_0200, 32'h0,         32'h1234_5678};
    vt[8]  = '{1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, 32'h1234_5678};
    vt[9]  = '{1'b0, 4'h0, 32'h8000_1004, 32'h0,         32'hCAFE_F00D};
    vt[10] = '{1'b0, 4'h0, 32'h0000_1004, 32'h0,         32'hCAFE_F00D};
    vt[11] = '{1'b1, 4'hF, 32'h0000_0300, 32'h1122_3344, 32'hCAFE_F00D};
    vt[12] = '{1'b1, 4'h9, 32'h0000_0300, 32'hAABB_CCDD, 32'hCAFE_F00D};
    vt[13] = '{1'b0, 4'h0, 32'h0000_0300, 32'h0,         32'hAA22_33DD};
    vt[14] = '{1'b0, 4'h0, 32'h0000_1300, 32'h0,         32'hAA22_33DD};

    resetn = 1'b0; req_a = 1'b0; req_b = 1'b0; wr = 1'b0;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_dok_a", {31'b0, dok_a}, 32'd0);
    check("rst_rd_a",  rd_a, 32'h0);
    check("rst_dok_b", {31'b0, dok_b}, 32'd0);
    check("rst_rd_b",  rd_b, 32'h0);
    resetn = 1'b1;
    check("first_aok_a", {31'b0, aok_a}, 32'd1);
    check("first_aok_b", {31'b0, aok_b}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      req_a = 1'b1; wr = vt[i].wr; wstrb = vt[i].strb; addr = vt[i].addr; wdata = vt[i].wdata;
      check($sformatf("vec%0d_aok", i), {31'b0, aok_a}, 32'd1);
      @(negedge clk);
      req_a = 1'b0;
      check($sformatf("vec%0d_dok", i), {31'b0, dok_a}, 32'd1);
      check($sformatf("vec%0d_rdata", i), rd_a, vt[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_dok_once", i), {31'b0, dok_a}, 32'd0);
    end

    // Back-to-back write then read of the same word.
    req_a = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h104; wdata = 32'h0BAD_CAFE;
    @(negedge clk);
    wr = 1'b0; addr = 32'h104;
    check("b2b_wr_dok", {31'b0, dok_a}, 32'd1);
    check("b2b_aok", {31'b0, aok_a}, 32'd1);
    @(negedge clk);
    req_a = 1'b0;
    check("b2b_rd_dok", {31'b0, dok_a}, 32'd1);
    check("b2b_rd_data", rd_a, 32'h0BAD_CAFE);
    @(negedge clk);
    check("b2b_idle", {31'b0, dok_a}, 32'd0);

    // Write signals with req low must not touch the array.
    wr = 1'b1; wstrb = 4'hF; addr = 32'h100; wdata = 32'h0;
    @(negedge clk);
    check("noreq_dok", {31'b0, dok_a}, 32'd0);
    req_a = 1'b1; wr = 1'b0;
    @(negedge clk);
    req_a = 1'b0;
    check("noreq_rd", rd_a, 32'hDEAD_AAEF);
    @(negedge clk);

    for (int k = 0; k < 6; k++) b_write(32'h40 + 32'(4 * k), 32'hB000_0000 + 32'(k));

    // Continuous request stream against LATENCY=3: stall pattern and in-order data.
    nacc = 0; nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      req_b = 1'b1; wr = 1'b0; addr = 32'h40 + 32'(4 * nacc);
      check($sformatf("strm%0d_aok", c), {31'b0, aok_b}, {31'b0, exp_ok[c]});
      check($sformatf("strm%0d_dok", c), {31'b0, dok_b}, {31'b0, exp_dok[c]});
      if (dok_b) begin
        check($sformatf("strm%0d_rdata", c), rd_b, 32'hB000_0000 + 32'(nrsp));
        nrsp++;
      end
      if (aok_b) nacc++;
      check($sformatf("strm%0d_outst_le2", c), {31'b0, (nacc - nrsp) <= 2}, 32'd1);
      @(negedge clk);
    end
    req_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (dok_b) begin
        check($sformatf("drain%0d_rdata", nrsp), rd_b, 32'hB000_0000 + 32'(nrsp));
        nrsp++;
      end
      @(negedge clk);
    end
    check("strm_rsp_count", nrsp, 32'd6);

    // Reset with two reads in flight.
    req_b = 1'b1; wr = 1'b0; addr = 32'h40;
    @(negedge clk);
    addr = 32'h44;
    @(negedge clk);
    req_b = 1'b0; resetn = 1'b0;
    check("inflight_aok_low", {31'b0, aok_b}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    check("postrst_aok", {31'b0, aok_b}, 32'd1);
    check("postrst_dok", {31'b0, dok_b}, 32'd0);
    check("postrst_rd",  rd_b, 32'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (dok_b) seen++;
      @(negedge clk);
    end
    check("postrst_no_rsp", seen, 32'd0);
    req_b = 1'b1; addr = 32'h48;
    @(negedge clk);
    req_b = 1'b0;
    wait_dok_b("retain_dok");
    check("retain_rd", rd_b, 32'hB000_0002);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, timeout reached");
    $fatal(1, "timeout");
  end

endmodule
